// File: rtl/neuron_integrator_if.sv
// Event-input, threshold-unit and spike-output signals of the neuron integrator.
// master = environment side, slave = integrator side.
interface neuron_integrator_if #(
    parameter int size_data = 8,
    parameter int size_vmem = 16,
    parameter int size_addr = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic        [size_addr-1:0] in_addr;
    logic signed [size_data-1:0] in_weight;
    logic                        step_start;
    logic                        busy;
    logic signed [size_vmem-1:0] impulse;
    logic                        update;
    logic                        out_spike;
    logic signed [size_vmem-1:0] out_vmem;
    logic                        spike_valid;
    logic                        spike_ready;
    logic        [size_addr-1:0] spike_addr;
    logic                        step_done;

    modport master (
        output in_valid, in_addr, in_weight, step_start, out_spike, out_vmem, spike_ready,
        input  in_ready, busy, impulse, update, spike_valid, spike_addr, step_done
    );

    modport slave (
        input  in_valid, in_addr, in_weight, step_start, out_spike, out_vmem, spike_ready,
        output in_ready, busy, impulse, update, spike_valid, spike_addr, step_done
    );
endinterface

// File: rtl/neuron_integrator.sv
// Per-neuron membrane accumulator with a timestep fire scan through an external
// combinational threshold unit; spikes leave as address events.
module neuron_integrator #(
    parameter int size_data   = 8,
    parameter int size_vmem   = 16,
    parameter int num_neurons = 16,
    parameter int size_addr   = 4
) (
    input logic                clk,
    input logic                rst_n,
    neuron_integrator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    localparam logic        [size_addr-1:0] LAST     = size_addr'(num_neurons - 1);
    localparam logic signed [size_vmem:0]   VMEM_MAX = (size_vmem+1)'((1 <<< (size_vmem - 1)) - 1);
    localparam logic signed [size_vmem:0]   VMEM_MIN = -(size_vmem+1)'(1 <<< (size_vmem - 1));

    state_t                      state;
    logic        [size_addr-1:0] idx;
    logic signed [size_vmem-1:0] vmem [num_neurons];
    logic                        accept;

    // One extra bit of headroom makes the clamp decision exact.
    function automatic logic signed [size_vmem-1:0] sat_add(
        input logic signed [size_vmem-1:0] a,
        input logic signed [size_data-1:0] w
    );
        logic signed [size_vmem:0] ae;
        logic signed [size_vmem:0] we;
        logic signed [size_vmem:0] sum;
        ae  = a;
        we  = w;
        sum = ae + we;
        if (sum > VMEM_MAX)
            return VMEM_MAX[size_vmem-1:0];
        else if (sum < VMEM_MIN)
            return VMEM_MIN[size_vmem-1:0];
        else
            return sum[size_vmem-1:0];
    endfunction

    assign accept = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.step_start) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (bus.out_spike)
                        state <= EMIT;
                    else if (idx == LAST)
                        state <= DONE;
                    else
                        idx <= idx + 1'b1;
                end
                EMIT: begin
                    if (bus.spike_ready) begin
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The scan write-back and event accumulation are mutually exclusive by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < num_neurons; k++)
                vmem[k] <= '0;
        end else if (state == SCAN) begin
            vmem[idx] <= bus.out_vmem;
        end else if (accept) begin
            vmem[bus.in_addr] <= sat_add(vmem[bus.in_addr], bus.in_weight);
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.update      = (state == SCAN);
    assign bus.impulse     = (state == SCAN) ? vmem[idx] : '0;
    assign bus.spike_valid = (state == EMIT);
    assign bus.spike_addr  = idx;
    assign bus.step_done   = (state == DONE);
endmodule

// File: tb/tb_neuron_integrator.sv
// Bench for neuron_integrator: vmem model, impulse/spike scoreboard queues,
// table-driven accumulation rows and hand-written backpressure/reset sequences.
module tb_neuron_integrator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_integrator_if #(.size_data(8), .size_vmem(16), .size_addr(4)) bus();

    neuron_integrator #(
        .size_data(8), .size_vmem(16), .num_neurons(16), .size_addr(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Threshold unit: fire at vmem >= 2^8, reset fired neuron to 0.
    always_comb begin
        bus.out_spike = bus.update && (bus.impulse >= 16'sd256);
        bus.out_vmem  = bus.out_spike ? 16'sd0 : bus.impulse;
    end

    int tests = 0;
    int fails = 0;
    int model[16];
    int imp_q[$];
    int spk_q[$];
    int obs_imp[16];
    int obs_spk[16];
    int scan_pos = 0;

    typedef struct {
        int addr;
        int weight;
        int reps;
        int exp_imp;
        int exp_spk;
        int exp_done;
    } row_t;
    row_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.update) begin
                if (scan_pos < 16) obs_imp[scan_pos] = int'(bus.impulse);
                scan_pos++;
                if (imp_q.size() == 0) check("imp_q_nonempty", imp_q.size(), 1);
                else check("impulse", int'(bus.impulse), imp_q.pop_front());
            end
            if (bus.spike_valid && bus.spike_ready) begin
                obs_spk[bus.spike_addr]++;
                if (spk_q.size() == 0) check("spk_q_nonempty", spk_q.size(), 1);
                else check("spike_addr", int'(bus.spike_addr), spk_q.pop_front());
            end
        end
    end

    task automatic send(input int addr, input int w, input int reps);
        for (int r = 0; r < reps; r++) begin
            bus.in_valid  = 1'b1;
            bus.in_addr   = 4'(addr);
            bus.in_weight = 8'(w);
            model[addr]   = sat16(model[addr] + w);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push_expect(output int nspk);
        nspk = 0;
        scan_pos = 0;
        for (int i = 0; i < 16; i++) begin
            obs_spk[i] = 0;
            imp_q.push_back(model[i]);
            if (model[i] >= 256) begin
                spk_q.push_back(i);
                model[i] = 0;
                nspk++;
            end
        end
    endtask

    task automatic run_scan(input int stall, input bit ev, input int ev_addr, input int ev_w,
                            output int done_cyc);
        int nspk;
        int seen = 0;
        int cnt = 0;
        int first_addr = -1;
        bit done = 1'b0;
        if (ev) begin
            bus.in_valid  = 1'b1;
            bus.in_addr   = 4'(ev_addr);
            bus.in_weight = 8'(ev_w);
            model[ev_addr] = sat16(model[ev_addr] + ev_w);
        end
        push_expect(nspk);
        bus.spike_ready = (stall == 0);
        bus.step_start  = 1'b1;
        tick();
        bus.step_start = 1'b0;
        bus.in_valid   = 1'b0;
        cnt = 1;
        check("busy_after_start", bus.busy, 1);
        check("in_ready_in_scan", bus.in_ready, 0);
        while (!done && cnt < 200) begin
            if (bus.step_done) begin
                done = 1'b1;
            end else begin
                if (bus.spike_valid && !bus.spike_ready) begin
                    if (first_addr < 0) first_addr = int'(bus.spike_addr);
                    else check("stall_addr_stable", int'(bus.spike_addr), first_addr);
                    check("stall_no_update", bus.update, 0);
                    seen++;
                    if (seen == stall + 1) bus.spike_ready = 1'b1;
                end
                tick();
                cnt++;
            end
        end
        check("scan_done_seen", done, 1);
        check("done_cycle_formula", cnt, 17 + nspk + stall);
        done_cyc = cnt;
        tick();
        check("done_one_cycle", bus.step_done, 0);
        check("busy_after_done", bus.busy, 0);
        check("in_ready_after_done", bus.in_ready, 1);
        check("imp_q_drained", imp_q.size(), 0);
        check("spk_q_drained", spk_q.size(), 0);
        bus.spike_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        int nspk;
        int w;
        bus.in_valid    = 1'b0;
        bus.in_addr     = '0;
        bus.in_weight   = '0;
        bus.step_start  = 1'b0;
        bus.spike_ready = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 0;

        tbl[0] = '{3,  100,   2,    200, 0, 17};
        tbl[1] = '{3,   55,   1,    255, 0, 17};
        tbl[2] = '{3,    1,   1,    256, 1, 18};
        tbl[3] = '{5, -128, 300, -32768, 0, 17};
        tbl[4] = '{5,  127,   1, -32641, 0, 17};
        tbl[5] = '{2,  127, 300,  32767, 1, 18};
        tbl[6] = '{7,  127,   3,    381, 1, 18};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_update", bus.update, 0);
        check("rst_spike_valid", bus.spike_valid, 0);
        check("rst_step_done", bus.step_done, 0);
        check("rst_impulse", int'(bus.impulse), 0);
        check("rst_spike_addr", int'(bus.spike_addr), 0);

        run_scan(0, 1'b0, 0, 0, dc);
        check("empty_scan_done_cycle", dc, 17);

        for (int r = 0; r < 7; r++) begin
            send(tbl[r].addr, tbl[r].weight, tbl[r].reps);
            run_scan(0, 1'b0, 0, 0, dc);
            check("row_impulse", obs_imp[tbl[r].addr], tbl[r].exp_imp);
            check("row_spike", obs_spk[tbl[r].addr], tbl[r].exp_spk);
            check("row_done_cycle", dc, tbl[r].exp_done);
        end

        send(0, 127, 3);
        send(15, 127, 3);
        run_scan(4, 1'b0, 0, 0, dc);
        check("bp_done_cycle", dc, 23);
        check("bp_spike0", obs_spk[0], 1);
        check("bp_spike15", obs_spk[15], 1);

        // Event in the start cycle pushes neuron 4 to exactly threshold.
        send(4, 127, 2);
        bus.in_valid    = 1'b1;
        bus.in_addr     = 4'd4;
        bus.in_weight   = 8'sd2;
        model[4]        = sat16(model[4] + 2);
        push_expect(nspk);
        bus.spike_ready = 1'b0;
        bus.step_start  = 1'b1;
        tick();
        bus.step_start = 1'b0;
        bus.in_valid   = 1'b0;
        w = 0;
        while (!bus.spike_valid && w < 40) begin
            tick();
            w++;
        end
        check("sim_emit_reached", bus.spike_valid, 1);
        check("sim_emit_addr", int'(bus.spike_addr), 4);
        check("sim_impulse4", obs_imp[4], 256);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_spike_valid", bus.spike_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_update", bus.update, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        imp_q.delete();
        spk_q.delete();
        for (int i = 0; i < 16; i++) model[i] = 0;
        bus.spike_ready = 1'b1;
        run_scan(0, 1'b0, 0, 0, dc);
        check("post_rst_done_cycle", dc, 17);
        check("post_rst_vmem4", obs_imp[4], 0);
        check("post_rst_vmem2", obs_imp[2], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/neuron_integrator.md
# neuron_integrator

Membrane-state owner for a layer of `num_neurons` neurons. It accumulates incoming weighted spike events into per-neuron signed membrane potentials (vmem). On a timestep boundary it scans every neuron through the combinational threshold unit, driving `impulse` and `update` and writing back the returned `out_vmem`. Each spike the threshold unit reports is emitted as a neuron-address event on a valid/ready output.

## Interface
- `size_data`, 8: width of signed synaptic weight; also the threshold exponent (a neuron fires when vmem ≥ 2^size_data).
- `size_vmem`, 16: width of signed membrane potential.
- `num_neurons`, 16: number of neurons held (≥2).
- `size_addr`, 4: neuron address width, = clog2(num_neurons).

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: weighted-event input valid.
- `in_ready` out 1: input accepted when `in_valid && in_ready`.
- `in_addr` in size_addr: target neuron of the event.
- `in_weight` in size_data: signed weight to add.
- `step_start` in 1: single-cycle pulse that ends the timestep and starts the fire scan.
- `busy` out 1: high from the cycle after `step_start` is accepted until `step_done`.
- `impulse` out size_vmem: vmem of the neuron under scan, to the threshold unit.
- `update` out 1: threshold-unit enable.
- `out_spike` in 1: combinational spike decision from the threshold unit.
- `out_vmem` in size_vmem: combinational post-threshold vmem from the threshold unit.
- `spike_valid` out 1 / `spike_ready` in 1 / `spike_addr` out size_addr: output spike-event handshake.
- `step_done` out 1: single-cycle pulse when the scan completes.

## Operation
- **Storage.** `num_neurons` × `size_vmem` register array, interpreted as two's complement.
- **States.**
  - IDLE: accumulate.
  - SCAN: one neuron per cycle.
  - EMIT: hold a spike event.
  - DONE: one cycle.
- **IDLE.**
  - `in_ready`=1.
  - On each accepted event: vmem[in_addr] ← sat(vmem[in_addr] + sext(in_weight)).
  - sat clamps to [−2^(size_vmem−1), 2^(size_vmem−1)−1].
  - Back-to-back events to the same address each apply, one per cycle, with no loss.
- **IDLE with `step_start`=1.**
  - An event accepted in the same cycle is applied first.
  - Next state is SCAN with index i=0.
- **`step_start` outside IDLE** is ignored.
- **SCAN.**
  - `in_ready`=0, `update`=1, `impulse`=vmem[i].
  - vmem[i] ← out_vmem at end of cycle.
  - If out_spike=1: go to EMIT with `spike_addr`=i.
  - Else if i=num_neurons−1: go to DONE.
  - Else: i ← i+1 and stay in SCAN.
- **EMIT.**
  - `spike_valid`=1 and `spike_addr` held stable; `update`=0, `impulse`=0.
  - On `spike_ready`: go to DONE if i=num_neurons−1, else i ← i+1 and return to SCAN.
- **DONE.** `step_done`=1 for one cycle, then IDLE.
- **Outside SCAN.** `impulse`=0 and `update`=0.
- **Reset (asynchronous, mid-operation included).**
  - State → IDLE, i=0, every vmem entry → 0.
  - Any pending spike event is dropped.

## Timing
- Reset values:
  - `in_ready`=1.
  - `busy`, `update`, `spike_valid`, `step_done` = 0.
  - `impulse`, `spike_addr` = 0.
- All outputs are decoded from registered state and index. `update` and `impulse` do not depend combinationally on any input.
- Input throughput is 1 event/cycle in IDLE.
- Scan length with `spike_ready` held high is num_neurons + S cycles in SCAN/EMIT, plus 1 DONE cycle, where S = spikes fired.
- The first SCAN cycle is the cycle after `step_start`.
- Each spike costs ≥1 EMIT cycle; backpressure on `spike_ready` stalls the scan indefinitely with vmem unchanged.
- `out_spike` and `out_vmem` are sampled only in SCAN cycles, in the same cycle `update`=1.

## Test plan
- **Reset, then scan with no events.**
  - Stimulus: reset, then pulse `step_start`.
  - Required: 16 SCAN cycles with impulse=0; no spike_valid; step_done 17 cycles after start; all vmem=0.
- **Accumulation below threshold.**
  - Stimulus: events (3,+100), (3,+100), (3,+55).
  - Required: at scan, impulse for neuron 3 = 255; no spike; vmem[3] stays 255.
- **Threshold crossing.**
  - Stimulus: from the previous state, add (3,+1) and start.
  - Required: impulse=256 at i=3, spike_addr=3 with spike_valid; vmem[3]=0 afterwards; step_done at cycle 18.
- **Saturation.**
  - Stimulus: 300 events of (5,−128).
  - Required: vmem[5]=−32768, no wrap to positive.
- **Backpressure.**
  - Stimulus: neurons 0 and 15 over threshold; `spike_ready` low for 4 cycles on the first event.
  - Required: spike_addr=0 held stable through the stall; events 0 then 15 are emitted; total scan 16+2+4 cycles.
- **Simultaneous event and mid-scan reset.**
  - Stimulus: `in_valid` and `step_start` in the same cycle; later, `rst_n` low during EMIT.
  - Required: the event is included in the scan; reset clears spike_valid and busy immediately and zeroes every vmem entry.
